exposure_readout_ctrl: RTL and testbench

Parametrised exposure and readout sequencer for the pixel-array front end. A single `init` pulse starts one frame. The block erases, exposes for a programmable number of cycles, then reads `NUM_ROWS` rows one after another. For each row it asserts that row's active-low read enable and pulses the ADC convert strobe, then returns to the erase/idle condition. It replaces the fixed two-row, fixed-timing controller and adds programmable exposure, per-row timing parameters, abort and frame-done status.

---
 rtl/exposure_readout_ctrl.sv | 153 +++++++++++++++
 tb/tb_exposure_readout_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exposure_readout_ctrl.sv
// Exposure and row-readout sequencer for the pixel array: erase, expose for a
// programmable time, then read NUM_ROWS rows with a settle/convert/hold cadence.
module exposure_readout_ctrl #(
  parameter int NUM_ROWS      = 2,
  parameter int EXP_W         = 5,
  parameter int SETTLE_CYCLES = 1,
  parameter int ADC_CYCLES    = 2,
  localparam int ROW_W        = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic                abort,
  input  logic [EXP_W-1:0]    exp_time,
  output logic                erase,
  output logic                expose,
  output logic                start,
  output logic [NUM_ROWS-1:0] nre,
  output logic                adc,
  output logic [ROW_W-1:0]    row_idx,
  output logic                busy,
  output logic                done
);

  localparam int PH_MAX = (SETTLE_CYCLES > ADC_CYCLES) ? SETTLE_CYCLES : ADC_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPOSE,
    S_RD_SETTLE,
    S_RD_CONV,
    S_RD_HOLD,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [EXP_W-1:0]   exp_cnt_q, exp_cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [ROW_W-1:0]   row_q, row_d;

  logic                erase_d, expose_d, start_d, adc_d, busy_d, done_d, read_d;
  logic [NUM_ROWS-1:0] nre_d;
  logic [ROW_W-1:0]    row_idx_d;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    exp_cnt_d = exp_cnt_q;
    phase_d   = phase_q;
    row_d     = row_q;

    unique case (state_q)
      S_IDLE: begin
        if (init) begin
          state_d   = S_EXPOSE;
          exp_cnt_d = (exp_time == '0) ? EXP_W'(1) : exp_time;
        end
      end
      S_EXPOSE: begin
        if (exp_cnt_q == EXP_W'(1)) begin
          state_d = S_RD_SETTLE;
          row_d   = '0;
          phase_d = '0;
        end else begin
          exp_cnt_d = exp_cnt_q - EXP_W'(1);
        end
      end
      S_RD_SETTLE: begin
        if (phase_q == PH_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_RD_CONV;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RD_CONV: begin
        if (phase_q == PH_W'(ADC_CYCLES - 1)) begin
          state_d = S_RD_HOLD;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_RD_HOLD: begin
        // Terminal compare rather than wrap keeps non-power-of-two row counts safe.
        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
          state_d = S_DONE;
          row_d   = '0;
        end else begin
          state_d = S_RD_SETTLE;
          row_d   = row_q + ROW_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      exp_cnt_d = '0;
      phase_d   = '0;
      row_d     = '0;
    end

    // Outputs are decoded from the next state and registered alongside it.
    read_d    = (state_d == S_RD_SETTLE) || (state_d == S_RD_CONV) || (state_d == S_RD_HOLD);
    erase_d   = (state_d == S_IDLE);
    expose_d  = (state_d == S_EXPOSE);
    start_d   = (state_d == S_EXPOSE) && (state_q == S_IDLE);
    adc_d     = (state_d == S_RD_CONV);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    row_idx_d = read_d ? row_d : '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      nre_d[i] = !(read_d && (row_d == ROW_W'(i)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      exp_cnt_q <= '0;
      phase_q   <= '0;
      row_q     <= '0;
      erase     <= 1'b1;
      expose    <= 1'b0;
      start     <= 1'b0;
      nre       <= '1;
      adc       <= 1'b0;
      row_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_cnt_q <= exp_cnt_d;
      phase_q   <= phase_d;
      row_q     <= row_d;
      erase     <= erase_d;
      expose    <= expose_d;
      start     <= start_d;
      nre       <= nre_d;
      adc       <= adc_d;
      row_idx   <= row_idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_exposure_readout_ctrl.sv
// Bench for exposure_readout_ctrl: default geometry (A) and a 3-row odd geometry
// (B); expected per-cycle output vectors are queued at stimulus time.
module tb_exposure_readout_ctrl;

  logic clk;
  logic reset;
  logic init_a, init_b;
  logic abort;
  logic [4:0] exp_time;

  logic       erase_a, expose_a, start_a, adc_a, busy_a, done_a;
  logic [1:0] nre_a;
  logic [0:0] row_idx_a;

  logic       erase_b, expose_b, start_b, adc_b, busy_b, done_b;
  logic [2:0] nre_b;
  logic [1:0] row_idx_b;

  typedef struct packed {
    logic       erase;
    logic       expose;
    logic       start;
    logic [3:0] nre;
    logic       adc;
    logic [1:0] row_idx;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t q_a[$];
  obs_t q_b[$];

  int    vectors;
  int    miscompares;
  string tag;

  exposure_readout_ctrl dut_a (
    .clk(clk), .reset(reset), .init(init_a), .abort(abort), .exp_time(exp_time),
    .erase(erase_a), .expose(expose_a), .start(start_a), .nre(nre_a), .adc(adc_a),
    .row_idx(row_idx_a), .busy(busy_a), .done(done_a)
  );

  exposure_readout_ctrl #(
    .NUM_ROWS(3), .EXP_W(5), .SETTLE_CYCLES(2), .ADC_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .init(init_b), .abort(abort), .exp_time(exp_time),
    .erase(erase_b), .expose(expose_b), .start(start_b), .nre(nre_b), .adc(adc_b),
    .row_idx(row_idx_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Expected outputs at cycle t after the accepting edge, from the frame timing formulas.
  function automatic obs_t model(int t, int e, int nr, int s, int a);
    obs_t m;
    int   p, u;
    logic [3:0] ones;
    ones  = 4'((1 << nr) - 1);
    m     = '0;
    m.nre = ones;
    p     = s + a + 1;
    if (t <= e) begin
      m.expose = 1'b1;
      m.start  = (t == 1);
      m.busy   = 1'b1;
    end else begin
      u = t - e - 1;
      if (u < nr * p) begin
        m.busy    = 1'b1;
        m.nre     = ones & ~(4'(1) << (u / p));
        m.adc     = ((u % p) >= s) && ((u % p) < s + a);
        m.row_idx = 2'(u / p);
      end else if (u == nr * p) begin
        m.busy = 1'b1;
        m.done = 1'b1;
      end else begin
        m.erase = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic int eff(int et);
    return (et == 0) ? 1 : et;
  endfunction

  task automatic push_partial_a(input int et, input int upto);
    for (int t = 1; t <= upto; t++) q_a.push_back(model(t, eff(et), 2, 1, 2));
  endtask

  task automatic push_frame_a(input int et);
    push_partial_a(et, eff(et) + 2 * 4 + 2);
  endtask

  task automatic push_frame_b(input int et);
    for (int t = 1; t <= eff(et) + 3 * 4 + 2; t++) q_b.push_back(model(t, eff(et), 3, 2, 1));
  endtask

  task automatic push_idle_a(input int n);
    for (int i = 0; i < n; i++) q_a.push_back(model(1000, 1, 2, 1, 2));
  endtask

  task automatic push_idle_b(input int n);
    for (int i = 0; i < n; i++) q_b.push_back(model(1000, 1, 3, 2, 1));
  endtask

  // One clock: sample #1 after the edge and compare against any queued expectation.
  task automatic cycle();
    obs_t e, o;
    @(posedge clk);
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      o = '{erase_a, expose_a, start_a, {2'b00, nre_a}, adc_a, {1'b0, row_idx_a}, busy_a, done_a};
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s dut_a: observed %b expected %b (erase,expose,start,nre,adc,row,busy,done)",
               tag, o, e);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      o = '{erase_b, expose_b, start_b, {1'b0, nre_b}, adc_b, row_idx_b, busy_b, done_b};
      vectors++;
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s dut_b: observed %b expected %b (erase,expose,start,nre,adc,row,busy,done)",
               tag, o, e);
      end
    end
  endtask

  task automatic drain();
    while ((q_a.size() > 0) || (q_b.size() > 0)) cycle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    init_a      = 1'b0;
    init_b      = 1'b0;
    abort       = 1'b0;
    exp_time    = 5'd0;

    tag = "reset_values";
    cycle();
    push_idle_a(2);
    push_idle_b(2);
    drain();
    reset = 1'b0;

    tag = "idle_hold";
    push_idle_a(20);
    push_idle_b(20);
    drain();

    tag = "nominal_exp5";
    exp_time = 5'd5;
    push_frame_a(5);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    drain();

    tag = "exp_zero";
    exp_time = 5'd0;
    push_frame_a(0);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    drain();

    tag = "exp_max31";
    exp_time = 5'd31;
    push_frame_a(31);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    drain();

    tag = "exp_change_mid";
    exp_time = 5'd10;
    push_frame_a(10);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    cycle();
    cycle();
    exp_time = 5'd2;
    drain();

    tag = "init_ignored_busy";
    exp_time = 5'd3;
    push_frame_a(3);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    cycle();
    init_a   = 1'b1;
    exp_time = 5'd20;
    cycle();
    init_a = 1'b0;
    drain();

    // Row 1 RD_CONV with E=5 is cycle 11; abort lands on the following edge.
    tag = "abort_row1_conv";
    exp_time = 5'd5;
    push_partial_a(5, 11);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    abort = 1'b1;
    push_idle_a(1);
    push_idle_b(1);
    cycle();
    abort = 1'b0;
    push_idle_a(2);
    drain();

    tag = "after_abort_frame";
    push_frame_a(5);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    drain();

    tag = "abort_and_init_idle";
    exp_time = 5'd2;
    push_frame_a(2);
    init_a = 1'b1;
    abort  = 1'b1;
    cycle();
    init_a = 1'b0;
    abort  = 1'b0;
    drain();

    tag = "odd_geometry";
    exp_time = 5'd3;
    push_frame_b(3);
    init_b = 1'b1;
    cycle();
    init_b = 1'b0;
    drain();

    tag = "reset_mid_expose";
    exp_time = 5'd10;
    push_partial_a(10, 3);
    init_a = 1'b1;
    cycle();
    init_a = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    push_idle_a(1);
    cycle();
    reset = 1'b0;
    push_idle_a(2);
    drain();

    tag = "init_held_back_to_back";
    exp_time = 5'd4;
    push_frame_a(4);
    push_frame_a(4);
    init_a = 1'b1;
    for (int i = 0; i < 2 * (4 + 2 * 4 + 2); i++) cycle();
    init_a = 1'b0;
    push_idle_a(2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
